output_port_arbiter: RTL and testbench

//  Wormhole arbiter for one router output port.
//  - Compares each input head flit's route address with PORT_ADDR.
//  - Grants one matching input (N,S,E,W,L) round-robin, then holds the grant until the tail flit is sent.
//  - Drives one-hot pops to the input FIFOs and the output crossbar mux select.
//  - One instance per output port, between the input FIFOs and the crossbar.

---
 rtl/noc_pkg.sv | 38 +++
 rtl/rr_priority_picker.sv | 42 ++++
 rtl/output_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_output_port_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared constants and types for the NoC router arbitration logic.
//   NUM_PORTS   number of router input ports (N, S, E, W, L)
//   ADDR_W      route address width carried in head flits
//   SEL_W       width of crossbar select / port index signals
//   port_e      port index encoding, N=0 .. L=4
//   arb_state_e output-port arbiter FSM states
//   next_port   wrap-around increment of a port index
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int ADDR_W    = 3;
  localparam int SEL_W     = 3;

  typedef enum logic [SEL_W-1:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index of the port after idx, wrapping from n-1 back to 0.
  function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] idx,
                                                 input int unsigned     n);
    logic [SEL_W-1:0] last;
    last = SEL_W'(n - 1);
    next_port = (idx == last) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: returns the first asserted request at or
// after rr_ptr_i, wrapping past NUM_PORTS-1 to 0. Reusable by any arbiter
// that keeps its own pointer register.
// Ports:
//   req_i      in  NUM_PORTS  request vector
//   rr_ptr_i   in  IDX_W      index where the search starts (< NUM_PORTS)
//   any_req_o  out 1          at least one request asserted
//   winner_o   out IDX_W      index of the selected request (0 when none)
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic                 any_req_o,
  output logic [IDX_W-1:0]     winner_o
);

  always_comb begin
    logic           found;
    logic [IDX_W:0] idx;
    any_req_o = |req_i;
    winner_o  = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      // Rotate the search origin; one extra bit keeps the sum from overflowing.
      idx = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_PORTS)) begin
        idx = idx - (IDX_W+1)'(NUM_PORTS);
      end
      if (!found && req_i[idx[IDX_W-1:0]]) begin
        found    = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
// Wormhole arbiter for one router output port. Inputs whose head flit routes
// to PORT_ADDR request the port; one is granted round-robin and keeps the
// port until its tail flit is transferred.
// Optional feature: define LOCK_TIMEOUT_EN to force release of a lock whose
// owner has had no flit for TIMEOUT_CYC consecutive cycles.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   req_addr_i   in   head-flit route address, port i at [i*ADDR_W +: ADDR_W]
//   valid_i      in   head flit present at input FIFO i
//   tail_i       in   head flit of input i is a tail flit
//   out_ready_i  in   downstream accepts a flit this cycle
//   pop_o        out  one-hot pop to the owning input FIFO
//   sel_o        out  crossbar select = owner index
//   out_valid_o  out  flit valid toward downstream
//   locked_o     out  an input currently owns this port
//   timeout_o    out  one-cycle pulse on forced release (0 unless enabled)
// ---------------------------------------------------------------------------
module output_port_arbiter #(
  parameter int                  NUM_PORTS   = noc_pkg::NUM_PORTS,
  parameter int                  ADDR_W      = noc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   PORT_ADDR   = '0,
  parameter int                  TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS-1:0]        valid_i,
  input  logic [NUM_PORTS-1:0]        tail_i,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS-1:0]        pop_o,
  output logic [2:0]                  sel_o,
  output logic                        out_valid_o,
  output logic                        locked_o,
  output logic                        timeout_o
);

  import noc_pkg::*;

  localparam int IDX_W = SEL_W;

  // Request decode: U-turns are deliberately not filtered here.
  logic [NUM_PORTS-1:0] req;
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
      assign req[gi] = valid_i[gi] && (req_addr_i[gi*ADDR_W +: ADDR_W] == PORT_ADDR);
    end
  endgenerate

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             any_req;
  logic [IDX_W-1:0] winner;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .winner_o  (winner)
  );

  logic owner_req;
  logic transfer;
  logic timeout_hit;

  assign owner_req = req[owner_q];
  assign transfer  = (state_q == ARB_LOCKED) && owner_req && out_ready_i;

`ifdef LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Fires on the TIMEOUT_CYC-th consecutive locked cycle without an owner flit.
  assign timeout_hit = (state_q == ARB_LOCKED) && !owner_req &&
                       (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == ARB_LOCKED) begin
      if (transfer || timeout_hit) begin
        idle_cnt_d = '0;
      end else if (!owner_req) begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end else begin
        // Owner has a flit but downstream stalls: not an idle owner.
        idle_cnt_d = idle_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d  = ARB_LOCKED;
          owner_d  = winner;
          rr_ptr_d = next_port(winner, NUM_PORTS);
        end
      end
      ARB_LOCKED: begin
        // A forced release leaves rr_ptr where the grant put it.
        if ((transfer && tail_i[owner_q]) || timeout_hit) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    pop_o       = '0;
    out_valid_o = 1'b0;
    locked_o    = (state_q == ARB_LOCKED);
    sel_o       = owner_q;
    timeout_o   = timeout_hit;
    if (state_q == ARB_LOCKED) begin
      out_valid_o = owner_req;
      if (transfer) begin
        pop_o[owner_q] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;

  localparam int NP = 5;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NP*AW-1:0] req_addr_i;
  logic [NP-1:0]    valid_i;
  logic [NP-1:0]    tail_i;
  logic             out_ready_i;
  logic [NP-1:0]    pop_o;
  logic [2:0]       sel_o;
  logic             out_valid_o;
  logic             locked_o;
  logic             timeout_o;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .NUM_PORTS   (NP),
    .ADDR_W      (AW),
    .PORT_ADDR   (3'd2),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_addr_i  (req_addr_i),
    .valid_i     (valid_i),
    .tail_i      (tail_i),
    .out_ready_i (out_ready_i),
    .pop_o       (pop_o),
    .sel_o       (sel_o),
    .out_valid_o (out_valid_o),
    .locked_o    (locked_o),
    .timeout_o   (timeout_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Bench-side input FIFO picture: flits left per port, a valid gate for
  // bubbles, and each port's head-flit address.
  int          cnt    [NP];
  logic        gate   [NP];
  logic [AW-1:0] addr_a [NP];
  logic        rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      valid_i[i] = (cnt[i] > 0) && gate[i];
      tail_i[i]  = (cnt[i] == 1);
      req_addr_i[i*AW +: AW] = addr_a[i];
    end
    out_ready_i = rdy;
  endtask

  // One clock cycle: drive, check the settled outputs, consume expected pops.
  task automatic cyc(input string tag, input logic e_lock, input logic [2:0] e_sel,
                     input logic e_ov, input logic [4:0] e_pop, input logic e_to);
    drive();
    #1;
    chk({tag, ".locked"}, 32'(locked_o), 32'(e_lock));
    if (e_lock) chk({tag, ".sel"}, 32'(sel_o), 32'(e_sel));
    chk({tag, ".valid"}, 32'(out_valid_o), 32'(e_ov));
    chk({tag, ".pop"}, 32'(pop_o), 32'(e_pop));
    chk({tag, ".timeout"}, 32'(timeout_o), 32'(e_to));
    $display("[TB] %s locked=%0d sel=%0d valid=%0d pop=%b", tag, locked_o, sel_o, out_valid_o, pop_o);
    for (int i = 0; i < NP; i++) begin
      if (e_pop[i]) cnt[i]--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".locked"}, 32'(locked_o), 32'd0);
    chk({tag, ".sel"}, 32'(sel_o), 32'd0);
    chk({tag, ".valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, ".pop"}, 32'(pop_o), 32'd0);
    chk({tag, ".timeout"}, 32'(timeout_o), 32'd0);
    $display("[TB] %s reset applied", tag);
    for (int i = 0; i < NP; i++) begin
      cnt[i]    = 0;
      gate[i]   = 1'b1;
      addr_a[i] = 3'd2;
    end
    rdy = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      cnt[i]    = 0;
      gate[i]   = 1'b1;
      addr_a[i] = 3'd2;
    end
    rdy = 1'b1;
    drive();
    #2;

    // T1: single-flit packet from N; S valid but routed elsewhere.
    do_reset("T1.rst");
    cnt[0] = 1; cnt[1] = 1; addr_a[1] = 3'd5;
    cyc("T1.c0", 0, 0, 0, 5'b00000, 0);
    cyc("T1.c1", 1, 0, 1, 5'b00001, 0);
    cyc("T1.c2", 0, 0, 0, 5'b00000, 0);
    cyc("T1.c3", 0, 0, 0, 5'b00000, 0);
    cnt[1] = 0; addr_a[1] = 3'd2;

    // T2: N, E, L single flits -> N, E, L with idle cycles; pointer back at 0.
    do_reset("T2.rst");
    cnt[0] = 1; cnt[2] = 1; cnt[4] = 1;
    cyc("T2.c0", 0, 0, 0, 5'b00000, 0);
    cyc("T2.c1", 1, 0, 1, 5'b00001, 0);
    cyc("T2.c2", 0, 0, 0, 5'b00000, 0);
    cyc("T2.c3", 1, 2, 1, 5'b00100, 0);
    cyc("T2.c4", 0, 0, 0, 5'b00000, 0);
    cyc("T2.c5", 1, 4, 1, 5'b10000, 0);
    cnt[0] = 1; cnt[1] = 1;
    cyc("T2.c6", 0, 0, 0, 5'b00000, 0);
    cyc("T2.c7", 1, 0, 1, 5'b00001, 0);
    cyc("T2.c8", 0, 0, 0, 5'b00000, 0);
    cyc("T2.c9", 1, 1, 1, 5'b00010, 0);
    cyc("T2.c10", 0, 0, 0, 5'b00000, 0);

    // T3: S 4-flit packet with a 3-cycle downstream stall.
    cnt[1] = 4;
    cyc("T3.c0", 0, 0, 0, 5'b00000, 0);
    cyc("T3.c1", 1, 1, 1, 5'b00010, 0);
    cyc("T3.c2", 1, 1, 1, 5'b00010, 0);
    rdy = 1'b0;
    cyc("T3.s0", 1, 1, 1, 5'b00000, 0);
    cyc("T3.s1", 1, 1, 1, 5'b00000, 0);
    cyc("T3.s2", 1, 1, 1, 5'b00000, 0);
    rdy = 1'b1;
    cyc("T3.c3", 1, 1, 1, 5'b00010, 0);
    cyc("T3.c4", 1, 1, 1, 5'b00010, 0);
    cyc("T3.c5", 0, 0, 0, 5'b00000, 0);

    // T4: W packet with a 2-cycle bubble while N waits.
    cnt[3] = 3;
    cyc("T4.c0", 0, 0, 0, 5'b00000, 0);
    cyc("T4.c1", 1, 3, 1, 5'b01000, 0);
    cnt[0] = 1; gate[3] = 1'b0;
    cyc("T4.b0", 1, 3, 0, 5'b00000, 0);
    cyc("T4.b1", 1, 3, 0, 5'b00000, 0);
    gate[3] = 1'b1;
    cyc("T4.c2", 1, 3, 1, 5'b01000, 0);
    cyc("T4.c3", 1, 3, 1, 5'b01000, 0);
    cyc("T4.c4", 0, 0, 0, 5'b00000, 0);
    cyc("T4.c5", 1, 0, 1, 5'b00001, 0);
    cyc("T4.c6", 0, 0, 0, 5'b00000, 0);

    // T5: reset mid-packet from E; next grant searches from port 0.
    cnt[2] = 3;
    cyc("T5.c0", 0, 0, 0, 5'b00000, 0);
    cyc("T5.c1", 1, 2, 1, 5'b00100, 0);
    do_reset("T5.rst");
    cnt[1] = 1; cnt[4] = 1;
    cyc("T5.c2", 0, 0, 0, 5'b00000, 0);
    cyc("T5.c3", 1, 1, 1, 5'b00010, 0);
    cyc("T5.c4", 0, 0, 0, 5'b00000, 0);
    cyc("T5.c5", 1, 4, 1, 5'b10000, 0);
    cyc("T5.c6", 0, 0, 0, 5'b00000, 0);

`ifdef LOCK_TIMEOUT_EN
    // T6: W stalls with valid low; forced release on the 4th idle cycle.
    cnt[3] = 3;
    cyc("T6.c0", 0, 0, 0, 5'b00000, 0);
    cyc("T6.c1", 1, 3, 1, 5'b01000, 0);
    gate[3] = 1'b0;
    cyc("T6.k1", 1, 3, 0, 5'b00000, 0);
    cyc("T6.k2", 1, 3, 0, 5'b00000, 0);
    cyc("T6.k3", 1, 3, 0, 5'b00000, 0);
    cyc("T6.k4", 1, 3, 0, 5'b00000, 1);
    cyc("T6.k5", 0, 0, 0, 5'b00000, 0);
    cnt[3] = 0; gate[3] = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
